// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch-to-decode instruction queue with show-ahead head and flush
// Optional same-cycle empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              flush_i,
    input  logic              fetch_valid_i,
    input  logic [ADDR_W-1:0] fetch_pc_i,
    input  logic [INST_W-1:0] fetch_inst_i,
    output logic              fetch_stall_o,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 2);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic empty, full, byp, pop, push, wr_en, rd_adv;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
`ifdef FETCH_QUEUE_BYPASS_EN
        // Bypass is blocked during reset so no partial entry leaks to decode.
        byp        = empty && fetch_valid_i && !flush_i && (rstn != `RstEnable);
        id_valid_o = !empty || byp;
        id_pc_o    = '0;
        id_inst_o  = '0;
        if (byp) begin
            id_pc_o   = fetch_pc_i;
            id_inst_o = fetch_inst_i;
        end else if (!empty) begin
            id_pc_o   = pc_mem[rd_ptr_q];
            id_inst_o = inst_mem[rd_ptr_q];
        end
`else
        byp        = 1'b0;
        id_valid_o = !empty;
        id_pc_o    = '0;
        id_inst_o  = '0;
        if (!empty) begin
            id_pc_o   = pc_mem[rd_ptr_q];
            id_inst_o = inst_mem[rd_ptr_q];
        end
`endif
        pop  = id_valid_o && id_ready_i && !flush_i;
        push = fetch_valid_i && !flush_i && (!full || pop);
        // A bypassed entry consumed in the same cycle never touches storage.
        wr_en  = push && !(byp && pop);
        rd_adv = pop && !byp;

        wr_ptr_d   = wr_en  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd_adv ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({wr_en, rd_adv})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | (fetch_valid_i && !flush_i && full && !pop);

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rstn == `RstEnable) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en && (rstn != `RstEnable)) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_i;
            inst_mem[wr_ptr_q] <= fetch_inst_i;
        end
    end

    assign fetch_stall_o = (count_q >= STALL_CNT);
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - vector table plus queue-model scoreboard for inst_fetch_queue
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              sys_clk = 1'b0;
    logic              rstn, flush_i, fetch_valid_i, id_ready_i;
    logic [31:0]       fetch_pc_i, fetch_inst_i;
    logic              fetch_stall_o, id_valid_o, overflow_o;
    logic [31:0]       id_pc_o, id_inst_o;
    logic [CNT_W-1:0]  count_o;

    inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32), .CNT_W(CNT_W)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .flush_i(flush_i),
        .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .fetch_inst_i(fetch_inst_i),
        .fetch_stall_o(fetch_stall_o), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        flush;
        logic        fv;
        logic [31:0] pc;
        logic        rdy;
        int          cnt;
        logic        vld;
        logic        stall;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    vec_t vecs[17];
    ent_t sb[$];
    logic ovf_m;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1234_5678;
    endfunction

    function automatic vec_t mk(input logic fl, input logic fv, input logic [31:0] pc, input logic rdy,
                                input int cnt, input logic vld, input logic stall, input logic ovf);
        vec_t v;
        v.flush = fl; v.fv = fv; v.pc = pc; v.rdy = rdy;
        v.cnt = cnt; v.vld = vld; v.stall = stall; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check head against the model, advance model, check state after edge.
    task automatic step(input logic fl, input logic fv, input logic [31:0] pc, input logic rdy);
        logic        exp_vld, pop, push, byp;
        logic [31:0] exp_pc, exp_inst;
        ent_t        e;
        @(negedge sys_clk);
        flush_i = fl; fetch_valid_i = fv; fetch_pc_i = pc; fetch_inst_i = inst_of(pc); id_ready_i = rdy;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (sb.size() == 0) && fv && !fl;
`else
        byp = 1'b0;
`endif
        exp_vld  = (sb.size() != 0) || byp;
        exp_pc   = 32'h0;
        exp_inst = 32'h0;
        if (sb.size() != 0) begin
            exp_pc = sb[0].pc; exp_inst = sb[0].inst;
        end else if (byp) begin
            exp_pc = pc; exp_inst = inst_of(pc);
        end
        chk("head_valid", 64'(id_valid_o), 64'(exp_vld));
        chk("head_pc", 64'(id_pc_o), 64'(exp_pc));
        chk("head_inst", 64'(id_inst_o), 64'(exp_inst));
        pop  = exp_vld && rdy && !fl;
        push = fv && !fl && ((sb.size() < DEPTH) || pop);
        if (fl) begin
            sb.delete();
        end else if (!(byp && pop)) begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                e.pc = pc; e.inst = inst_of(pc);
                sb.push_back(e);
            end
            if (fv && !push) ovf_m = 1'b1;
        end
        @(posedge sys_clk);
        #1;
        chk("model_count", 64'(count_o), 64'(sb.size()));
        chk("model_overflow", 64'(overflow_o), 64'(ovf_m));
    endtask

    initial begin
        vecs[0]  = mk(0, 1, 32'h00, 0, 1, 1, 0, 0);
        vecs[1]  = mk(0, 1, 32'h04, 0, 2, 1, 1, 0);
        vecs[2]  = mk(0, 1, 32'h08, 0, 3, 1, 1, 0);
        vecs[3]  = mk(0, 1, 32'h0C, 0, 4, 1, 1, 0);
        vecs[4]  = mk(0, 1, 32'h10, 1, 4, 1, 1, 0);
        vecs[5]  = mk(0, 1, 32'h14, 0, 4, 1, 1, 1);
        vecs[6]  = mk(0, 0, 32'h00, 1, 3, 1, 1, 1);
        vecs[7]  = mk(0, 0, 32'h00, 1, 2, 1, 1, 1);
        vecs[8]  = mk(0, 0, 32'h00, 1, 1, 1, 0, 1);
        vecs[9]  = mk(0, 0, 32'h00, 1, 0, 0, 0, 1);
        vecs[10] = mk(0, 0, 32'h00, 1, 0, 0, 0, 1);
        vecs[11] = mk(0, 1, 32'h20, 0, 1, 1, 0, 1);
        vecs[12] = mk(0, 1, 32'h24, 0, 2, 1, 1, 1);
        vecs[13] = mk(0, 1, 32'h28, 0, 3, 1, 1, 1);
        vecs[14] = mk(1, 1, 32'h2C, 1, 0, 0, 0, 1);
        vecs[15] = mk(0, 1, 32'h40, 0, 1, 1, 0, 1);
        vecs[16] = mk(0, 0, 32'h00, 1, 0, 0, 0, 1);

        ovf_m = 1'b0;
        rstn = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b1; fetch_pc_i = 32'h100;
        fetch_inst_i = inst_of(32'h100); id_ready_i = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(id_valid_o), 64'd0);
        chk("rst_pc", 64'(id_pc_o), 64'd0);
        chk("rst_stall", 64'(fetch_stall_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        @(negedge sys_clk);
        rstn = 1'b0; fetch_valid_i = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].flush, vecs[i].fv, vecs[i].pc, vecs[i].rdy);
            chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d_valid", i), 64'(id_valid_o), 64'(vecs[i].vld));
            chk($sformatf("vec%0d_stall", i), 64'(fetch_stall_o), 64'(vecs[i].stall));
            chk($sformatf("vec%0d_overflow", i), 64'(overflow_o), 64'(vecs[i].ovf));
        end

        // Empty queue, fetch with decode ready: bypass or one-cycle latency.
        step(0, 1, 32'h80, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("bypass_count", 64'(count_o), 64'd0);
`else
        chk("nobypass_count", 64'(count_o), 64'd1);
        step(0, 0, 32'h0, 1);
        chk("nobypass_drain", 64'(count_o), 64'd0);
`endif

        // Reset in the middle of a stream clears entries and the sticky overflow.
        step(0, 1, 32'hA0, 0);
        step(0, 1, 32'hA4, 0);
        @(negedge sys_clk);
        rstn = 1'b1; fetch_valid_i = 1'b1; fetch_pc_i = 32'hA8; fetch_inst_i = inst_of(32'hA8);
        @(posedge sys_clk);
        #1;
        chk("midrst_count", 64'(count_o), 64'd0);
        chk("midrst_valid", 64'(id_valid_o), 64'd0);
        chk("midrst_pc", 64'(id_pc_o), 64'd0);
        chk("midrst_overflow", 64'(overflow_o), 64'd0);
        sb.delete();
        ovf_m = 1'b0;
        @(negedge sys_clk);
        rstn = 1'b0; fetch_valid_i = 1'b0;
        step(0, 1, 32'hC0, 0);
        chk("post_rst_count", 64'(count_o), 64'd1);
        step(0, 0, 32'h0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Buffers fetched instructions between the PC/instruction-memory pair and the decode stage.
- Each entry holds {pc, inst} and is captured on each valid fetch response.
- Presents the oldest entry to decode through a valid/ready handshake.
- Throttles fetch through a stall output, and drops all contents on a branch/exception flush.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 4
ADDR_W, 32, PC width (matches InstAddrBus)
INST_W, 32, instruction width
CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
sys_clk  input  1  system clock; all state updates on rising edge
rstn  input  1  reset; synchronous, active-high (asserted when rstn == `RstEnable, `RstEnable = 1'b1)
flush_i  input  1  discard all entries, including any push in the same cycle
fetch_valid_i  input  1  fetch response valid this cycle
fetch_pc_i  input  ADDR_W  PC of the fetched instruction
fetch_inst_i  input  INST_W  fetched instruction word
fetch_stall_o  output  1  request to hold the PC/chip-enable
id_valid_o  output  1  head entry valid for decode
id_ready_i  input  1  decode accepts the head entry this cycle
id_pc_o  output  ADDR_W  head entry PC
id_inst_o  output  INST_W  head entry instruction
count_o  output  CNT_W  current occupancy
overflow_o  output  1  sticky: a push arrived while full with no pop

Behaviour:
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus count register.
- Reset (rstn high at edge): wr_ptr, rd_ptr, count, overflow_o = 0. id_valid_o = 0, fetch_stall_o = 0, id_pc_o = 0, id_inst_o = 0. Storage contents are don't-care.
- push = fetch_valid_i && !flush_i && (count < DEPTH || pop).
- pop = id_valid_o && id_ready_i && !flush_i.
- Push writes {fetch_pc_i, fetch_inst_i} at wr_ptr; wr_ptr += 1.
- Pop advances rd_ptr += 1.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged. This is legal at count == 0 only with bypass (see Optional Feature); legal at count == DEPTH.
- Show-ahead: id_valid_o = (count != 0). id_pc_o/id_inst_o = entry at rd_ptr when valid, else 0.
- Push-to-visible latency: entry pushed in cycle N appears on id_* in cycle N+1.
- Decode holding id_ready_i low keeps id_* stable.
- fetch_stall_o = (count >= DEPTH-2), derived from the registered count. The margin covers the one-cycle instruction-memory latency plus one in-flight response.
- Full with no pop: incoming fetch_valid_i is dropped and overflow_o sets to 1. overflow_o clears only on reset.
- Empty with id_ready_i high: no effect; pointers are unchanged.
- Flush: next cycle wr_ptr = rd_ptr = count = 0 and id_valid_o = 0.
  - The push and pop in the flush cycle are both suppressed.
  - overflow_o is unaffected.
- Priority: reset > flush > push/pop.
- Reset asserted mid-stream discards all entries with no partial outputs.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined: when count == 0 and fetch_valid_i && !flush_i, the incoming {pc, inst} drives id_* combinationally and id_valid_o = 1 in the same cycle.
  - If id_ready_i is also high, the entry is consumed without being written; pointers and count are unchanged.
  - Otherwise it is written normally.
- Undefined: no combinational path from fetch_* to id_*. Minimum latency is 1 cycle and id_* are purely register/storage driven.

Test Plan:
- Reset: hold rstn=1 for 2 cycles with fetch_valid_i=1 -> count_o=0, id_valid_o=0, id_pc_o=0, fetch_stall_o=0, overflow_o=0.
- In-order fill/drain: push PCs 0x0,0x4,0x8,0xC with id_ready_i=0 -> count_o reaches 4 and fetch_stall_o=1 from count 2. Then id_ready_i=1 -> id_pc_o sequence 0x0,0x4,0x8,0xC, then id_valid_o=0.
- Full with simultaneous push/pop: at count 4, push 0x10 while id_ready_i=1 -> count stays 4, overflow_o=0, 0x10 emerges after 0xC (wrap-around verified).
- Overflow: at count 4, push 0x14 with id_ready_i=0 -> count stays 4, overflow_o=1 and remains 1 through a flush; cleared only by reset.
- Flush: at count 3, assert flush_i with fetch_valid_i=1 and id_ready_i=1 -> next cycle count_o=0, id_valid_o=0. The next push of 0x40 appears at id_pc_o one cycle later.
- Bypass (macro defined): queue empty, push 0x80 with id_ready_i=1 -> id_valid_o=1 and id_pc_o=0x80 in the same cycle, count_o stays 0. Macro undefined -> 0x80 appears the next cycle with count_o=1.
